// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU opcodes and width constants
package alu_share_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int OP_W     = 4;
    localparam int NREQ_MAX = 4;

    typedef enum logic [OP_W-1:0] {
        ALUOP_ADD  = 4'h0,
        ALUOP_SUB  = 4'h1,
        ALUOP_AND  = 4'h2,
        ALUOP_OR   = 4'h3,
        ALUOP_XOR  = 4'h4,
        ALUOP_SLL  = 4'h5,
        ALUOP_SRL  = 4'h6,
        ALUOP_SRA  = 4'h7,
        ALUOP_SLT  = 4'h8,
        ALUOP_SLTU = 4'h9
    } aluop_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational 32-bit integer ALU
// Ports:
//   a, b   : operands
//   op     : ALUOP code; codes outside aluop_e yield 0
//   result : wrapped 32-bit result, compares zero-extended
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALUOP_ADD:  result = a + b;
            ALUOP_SUB:  result = a - b;
            ALUOP_AND:  result = a & b;
            ALUOP_OR:   result = a | b;
            ALUOP_XOR:  result = a ^ b;
            ALUOP_SLL:  result = a << b[4:0];
            ALUOP_SRL:  result = a >> b[4:0];
            ALUOP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALUOP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU with a 1-deep response stage
// Ports:
//   clk_i, rst_n_i      : clock (rising edge), async active-low reset
//   flush_i             : drop held response, block acceptance this cycle
//   req_valid_i/ready_o : per-requester request handshake (ready one-hot or zero)
//   req_val1_i/val2_i   : packed 32-bit operands, requester k at [32k+31:32k]
//   req_aluop_i         : packed 4-bit ALUOP codes
//   rsp_valid_o/ready_i : per-requester response handshake (valid one-hot to owner)
//   rsp_data_o          : registered ALU result shared by all requesters
//   busy_o              : a response is held
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*DATA_W-1:0] req_val1_i,
    input  logic [NREQ*DATA_W-1:0] req_val2_i,
    input  logic [NREQ*OP_W-1:0]   req_aluop_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    input  logic [NREQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   busy_o
);

    logic [IDXW-1:0]   owner;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   gnt_idx;
    logic [IDXW-1:0]   rr_ptr_nxt;
    logic [NREQ-1:0]   grant;
    logic              found;
    logic              consume;
    logic              free;
    logic [DATA_W-1:0] sel_val1;
    logic [DATA_W-1:0] sel_val2;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] alu_result;

    assign busy_o = |rsp_valid_o;

    // Owner consumes this cycle; loop keeps the index width-exact for any NREQ.
    always_comb begin
        consume = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner == IDXW'(k)) begin
                consume = rsp_valid_o[k] & rsp_ready_i[k];
            end
        end
    end

    // Consuming frees the stage, so a new op can pass through in the same cycle.
    assign free = !busy_o | consume;

    // Round-robin: visit offsets 0..NREQ-1 from the pointer; first valid wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (free && !flush_i) begin
            for (int i = 0; i < NREQ; i++) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && (k == (int'(rr_ptr) + i) % NREQ) && req_valid_i[k]) begin
                        found    = 1'b1;
                        grant[k] = 1'b1;
                        gnt_idx  = IDXW'(k);
                    end
                end
            end
        end
    end

    assign req_ready_o = grant;
    assign rr_ptr_nxt  = (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + IDXW'(1);

    // Only the granted requester's operands reach the ALU.
    always_comb begin
        sel_val1 = '0;
        sel_val2 = '0;
        sel_op   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDXW'(k)) begin
                sel_val1 = req_val1_i[k*DATA_W +: DATA_W];
                sel_val2 = req_val2_i[k*DATA_W +: DATA_W];
                sel_op   = req_aluop_i[k*OP_W +: OP_W];
            end
        end
    end

    alu_share_arbiter_alu u_alu (
        .a      (sel_val1),
        .b      (sel_val2),
        .op     (sel_op),
        .result (alu_result)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
        end else if (flush_i) begin
            // Flush wins over a simultaneous consume; grant is already blocked.
            rsp_valid_o <= '0;
        end else if (found) begin
            rsp_data_o  <= alu_result;
            owner       <= gnt_idx;
            rsp_valid_o <= grant;
            rr_ptr      <= rr_ptr_nxt;
        end else if (consume) begin
            rsp_valid_o <= '0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int IDXW = 2;

    logic                   clk_i;
    logic                   rst_n_i;
    logic                   flush_i;
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*32-1:0]     req_val1_i;
    logic [NREQ*32-1:0]     req_val2_i;
    logic [NREQ*4-1:0]      req_aluop_i;
    logic [NREQ-1:0]        rsp_valid_o;
    logic [NREQ-1:0]        rsp_ready_i;
    logic [31:0]            rsp_data_o;
    logic                   busy_o;

    alu_share_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_val1_i  (req_val1_i),
        .req_val2_i  (req_val2_i),
        .req_aluop_i (req_aluop_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  rdy;
        logic        flush;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  e_rr;
        logic [1:0]  e_rv;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t v(input logic [1:0] vld, input logic [1:0] rdy, input logic flush,
                               input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] e_rr, input logic [1:0] e_rv, input logic [31:0] e_d);
        vec_t r;
        r.vld = vld; r.rdy = rdy; r.flush = flush;
        r.op0 = op0; r.a0 = a0; r.b0 = b0;
        r.op1 = op1; r.a1 = a1; r.b1 = b1;
        r.e_rr = e_rr; r.e_rv = e_rv; r.e_d = e_d;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h, want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] e_rr, input logic [1:0] e_rv, input logic [31:0] e_d);
        check("req_ready", idx, 32'(req_ready_o), 32'(e_rr));
        check("rsp_valid", idx, 32'(rsp_valid_o), 32'(e_rv));
        check("rsp_data", idx, rsp_data_o, e_d);
        check("busy", idx, 32'(busy_o), {31'b0, (e_rv != 2'b00)});
    endtask

    localparam logic [3:0] ADD  = ALUOP_ADD;
    localparam logic [3:0] SUB  = ALUOP_SUB;
    localparam logic [3:0] OR_  = ALUOP_OR;
    localparam logic [3:0] SLT  = ALUOP_SLT;
    localparam logic [3:0] SLTU = ALUOP_SLTU;
    localparam logic [3:0] SRA  = ALUOP_SRA;
    localparam logic [3:0] UNDF = 4'hF;

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_val1_i  = '0;
        req_val2_i  = '0;
        req_aluop_i = '0;

        // Idle after reset
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(2'b00, 2'b00, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b00, 32'd0));
        // Single requester add, 1-cycle latency
        tbl.push_back(v(2'b01, 2'b11, 0, ADD, 5, 7, ADD, 0, 0, 2'b01, 2'b00, 32'd0));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b01, 32'd12));
        // Both valid, alternating grants, pointer starts at 1
        tbl.push_back(v(2'b11, 2'b11, 0, SUB, 10, 3, SUB, 20, 5, 2'b10, 2'b00, 32'd12));
        tbl.push_back(v(2'b11, 2'b11, 0, SUB, 10, 3, SUB, 20, 5, 2'b01, 2'b10, 32'd15));
        tbl.push_back(v(2'b11, 2'b11, 0, SUB, 10, 3, SUB, 20, 5, 2'b10, 2'b01, 32'd7));
        tbl.push_back(v(2'b11, 2'b11, 0, SUB, 10, 3, SUB, 20, 5, 2'b01, 2'b10, 32'd15));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b01, 32'd7));
        // Owner stall
        tbl.push_back(v(2'b10, 2'b11, 0, ADD, 0, 0, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b10, 2'b00, 32'd7));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(2'b01, 2'b01, 0, ADD, 5, 7, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b00, 2'b10, 32'hFFFF_FFFF));
        tbl.push_back(v(2'b01, 2'b11, 0, ADD, 5, 7, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b01, 2'b10, 32'hFFFF_FFFF));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b01, 32'd12));
        // Flush with a held response, owner consuming at the same time
        tbl.push_back(v(2'b10, 2'b00, 0, ADD, 5, 7, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b10, 2'b00, 32'd12));
        tbl.push_back(v(2'b11, 2'b10, 1, ADD, 5, 7, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b00, 2'b10, 32'hFFFF_FFFF));
        tbl.push_back(v(2'b11, 2'b11, 0, ADD, 5, 7, OR_, 32'hFFFF_0000, 32'h0000_FFFF, 2'b01, 2'b00, 32'hFFFF_FFFF));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b01, 32'd12));
        // Edge operands on requester 1
        tbl.push_back(v(2'b10, 2'b11, 0, ADD, 0, 0, SLT, 32'h8000_0000, 1, 2'b10, 2'b00, 32'd12));
        tbl.push_back(v(2'b10, 2'b11, 0, ADD, 0, 0, SLTU, 32'h8000_0000, 1, 2'b10, 2'b10, 32'd1));
        tbl.push_back(v(2'b10, 2'b11, 0, ADD, 0, 0, SRA, 32'h8000_0000, 4, 2'b10, 2'b10, 32'd0));
        tbl.push_back(v(2'b10, 2'b11, 0, ADD, 0, 0, UNDF, 32'h123, 32'h456, 2'b10, 2'b10, 32'hF800_0000));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b10, 32'd0));
        tbl.push_back(v(2'b00, 2'b11, 0, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b00, 32'd0));

        #3;
        check_all(-1, 2'b00, 2'b00, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk_i);
            #1;
            req_valid_i = tbl[i].vld;
            rsp_ready_i = tbl[i].rdy;
            flush_i     = tbl[i].flush;
            req_val1_i  = {tbl[i].a1, tbl[i].a0};
            req_val2_i  = {tbl[i].b1, tbl[i].b0};
            req_aluop_i = {tbl[i].op1, tbl[i].op0};
            @(negedge clk_i);
            check_all(i, tbl[i].e_rr, tbl[i].e_rv, tbl[i].e_d);
        end

        // Reset in the middle of a held response
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b01;
        rsp_ready_i = 2'b00;
        flush_i     = 1'b0;
        req_val1_i  = {32'd0, 32'd5};
        req_val2_i  = {32'd0, 32'd7};
        req_aluop_i = {ADD, ADD};
        @(posedge clk_i);
        #1;
        req_valid_i = 2'b00;
        check_all(100, 2'b00, 2'b01, 32'd12);
        #2 rst_n_i = 1'b0;
        #1;
        check_all(101, 2'b00, 2'b00, 32'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_all(102 + i, 2'b00, 2'b00, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
